systolic_feed_sched: RTL and testbench

SYSTOLIC_FEED_SCHED -- requirements
Module: systolic_feed_sched

---
 rtl/sched_pkg.sv | 20 ++
 rtl/skew_lane_mux.sv | 28 ++
 rtl/systolic_feed_sched.sv | 100 ++++++++++
 tb/tb_systolic_feed_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared FSM state encoding and feed-schedule constants
package sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam int DEFAULT_DIMENSION = 4;
   localparam int FEED_STEPS        = 2 * DEFAULT_DIMENSION - 1;

   // Number of skewed feed steps for an arbitrary array side length.
   function automatic int feed_steps(input int dimension);
      return 2 * dimension - 1;
   endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// rtl/skew_lane_mux.sv - per-lane skewed operand select for one array edge
module skew_lane_mux #(
   parameter int DIMENSION   = 4,
   parameter int I_BITS      = 8,
   parameter int TW          = 3,
   parameter bit COLUMN_FEED = 1'b0
) (
   input  logic [DIMENSION*DIMENSION*I_BITS-1:0] store,
   input  logic [TW-1:0]                         step,
   output logic [DIMENSION*I_BITS-1:0]           lanes
);

   // Lane n carries element k of its row (or column) when step == n + k; otherwise zero.
   always_comb begin
      lanes = '0;
      for (int lane = 0; lane < DIMENSION; lane++) begin
         for (int k = 0; k < DIMENSION; k++) begin
            if (int'(step) == lane + k) begin
               if (COLUMN_FEED)
                  lanes[lane*I_BITS +: I_BITS] = store[(k*DIMENSION + lane)*I_BITS +: I_BITS];
               else
                  lanes[lane*I_BITS +: I_BITS] = store[(lane*DIMENSION + k)*I_BITS +: I_BITS];
            end
         end
      end
   end

endmodule

// File: rtl/systolic_feed_sched.sv
// rtl/systolic_feed_sched.sv - operand stores and skewed feed sequencer for a systolic array
module systolic_feed_sched
   import sched_pkg::*;
#(
   parameter int DIMENSION = 4,
   parameter int I_BITS    = 8,
   parameter int AW        = $clog2(DIMENSION)
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_wr_en,
   input  logic                        i_wr_sel,
   input  logic [AW-1:0]               i_wr_row,
   input  logic [AW-1:0]               i_wr_col,
   input  logic [I_BITS-1:0]           i_wr_data,
   input  logic                        i_start,
   input  logic                        i_array_finish,
   output logic                        o_array_reset,
   output logic [DIMENSION*I_BITS-1:0] o_a,
   output logic [DIMENSION*I_BITS-1:0] o_b,
   output logic                        o_busy,
   output logic                        o_done
);

   localparam int STEPS = feed_steps(DIMENSION);
   localparam int TW    = $clog2(STEPS + 1);
   localparam int SW    = DIMENSION * DIMENSION * I_BITS;
   localparam logic [TW-1:0] LAST_STEP = TW'(STEPS - 1);

   state_t                      state, state_next;
   logic [TW-1:0]               step, step_next;
   logic [SW-1:0]               store_a, store_b;
   logic [DIMENSION*I_BITS-1:0] lanes_a, lanes_b, a_q, b_q;
   logic                        wr_ok;

   assign wr_ok = i_wr_en && (state == ST_IDLE)
               && (int'(i_wr_row) < DIMENSION) && (int'(i_wr_col) < DIMENSION);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         store_a <= '0;
         store_b <= '0;
      end else if (wr_ok) begin
         if (i_wr_sel)
            store_b[(int'(i_wr_row)*DIMENSION + int'(i_wr_col))*I_BITS +: I_BITS] <= i_wr_data;
         else
            store_a[(int'(i_wr_row)*DIMENSION + int'(i_wr_col))*I_BITS +: I_BITS] <= i_wr_data;
      end
   end

   always_comb begin
      state_next = state;
      step_next  = '0;
      case (state)
         ST_IDLE:  if (i_start) state_next = ST_CLEAR;
         ST_CLEAR: state_next = ST_FEED;
         ST_FEED: begin
            if (step == LAST_STEP) state_next = ST_WAIT;
            else                   step_next  = step + 1'b1;
         end
         ST_WAIT:  if (i_array_finish) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Lanes are computed from the upcoming step so the registered value lines up with step.
   skew_lane_mux #(
      .DIMENSION(DIMENSION), .I_BITS(I_BITS), .TW(TW), .COLUMN_FEED(1'b0)
   ) u_mux_a (
      .store(store_a), .step(step_next), .lanes(lanes_a)
   );

   skew_lane_mux #(
      .DIMENSION(DIMENSION), .I_BITS(I_BITS), .TW(TW), .COLUMN_FEED(1'b1)
   ) u_mux_b (
      .store(store_b), .step(step_next), .lanes(lanes_b)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= ST_IDLE;
         step  <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         state <= state_next;
         step  <= step_next;
         a_q   <= (state_next == ST_FEED) ? lanes_a : '0;
         b_q   <= (state_next == ST_FEED) ? lanes_b : '0;
      end
   end

   assign o_array_reset = !i_reset && (state == ST_CLEAR);
   assign o_busy        = !i_reset && (state != ST_IDLE);
   assign o_done        = !i_reset && (state == ST_DONE);
   assign o_a           = i_reset ? '0 : a_q;
   assign o_b           = i_reset ? '0 : b_q;

endmodule

// File: tb/tb_systolic_feed_sched.sv
// tb/tb_systolic_feed_sched.sv - scoreboard bench for systolic_feed_sched
module tb_systolic_feed_sched;

   localparam int D  = 4;
   localparam int IB = 8;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_wr_en = 1'b0;
   logic          i_wr_sel = 1'b0;
   logic [2:0]    i_wr_row = '0;
   logic [2:0]    i_wr_col = '0;
   logic [IB-1:0] i_wr_data = '0;
   logic          i_start = 1'b0;
   logic          i_array_finish = 1'b0;
   logic          o_array_reset;
   logic [D*IB-1:0] o_a, o_b;
   logic          o_busy, o_done;

   systolic_feed_sched #(.DIMENSION(D), .I_BITS(IB), .AW(3)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
      .i_wr_row(i_wr_row), .i_wr_col(i_wr_col), .i_wr_data(i_wr_data),
      .i_start(i_start), .i_array_finish(i_array_finish),
      .o_array_reset(o_array_reset), .o_a(o_a), .o_b(o_b),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic [D*IB-1:0] a;
      logic [D*IB-1:0] b;
   } feed_t;

   feed_t      exp_feed[$];
   bit         exp_done_q[$];
   logic [7:0] ma [D][D];
   logic [7:0] mb [D][D];
   int         n_checks = 0;
   int         n_fail = 0;
   int         feed_left = 0;
   int         clears = 0;
   int         runs = 0;
   feed_t      mon_e;

   function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endfunction

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic clear_model();
      for (int r = 0; r < D; r++)
         for (int c = 0; c < D; c++) begin
            ma[r][c] = '0;
            mb[r][c] = '0;
         end
   endtask

   task automatic write_el(input bit sel, input int row, input int col, input logic [7:0] data);
      i_wr_en = 1'b1; i_wr_sel = sel; i_wr_row = 3'(row); i_wr_col = 3'(col); i_wr_data = data;
      tick();
      i_wr_en = 1'b0;
      if (row < D && col < D) begin
         if (sel) mb[row][col] = data;
         else     ma[row][col] = data;
      end
   endtask

   // Expected lane contents for every feed step, straight from the skew rule.
   task automatic push_expected();
      feed_t e;
      for (int t = 0; t < 2*D-1; t++) begin
         e.a = '0;
         e.b = '0;
         for (int n = 0; n < D; n++) begin
            if (t - n >= 0 && t - n < D) begin
               e.a[n*IB +: IB] = ma[n][t-n];
               e.b[n*IB +: IB] = mb[t-n][n];
            end
         end
         exp_feed.push_back(e);
      end
      exp_done_q.push_back(1'b1);
      runs++;
   endtask

   task automatic run_mult(input int wait_cycles, input bit spam, input bit fwrite, input bit wr_start);
      if (wr_start) begin
         i_wr_en = 1'b1; i_wr_sel = 1'($urandom_range(0, 1));
         i_wr_row = 3'($urandom_range(0, D-1)); i_wr_col = 3'($urandom_range(0, D-1));
         i_wr_data = 8'($urandom);
         if (i_wr_sel) mb[i_wr_row][i_wr_col] = i_wr_data;
         else          ma[i_wr_row][i_wr_col] = i_wr_data;
      end
      push_expected();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_wr_en = 1'b0;
      for (int c = 0; c < 2*D; c++) begin
         i_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         if (fwrite) begin
            i_wr_en   = 1'b1;
            i_wr_sel  = (c == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            i_wr_row  = (c == 3) ? 3'd1 : 3'($urandom_range(0, D-1));
            i_wr_col  = (c == 3) ? 3'd2 : 3'($urandom_range(0, D-1));
            i_wr_data = (c == 3) ? 8'h55 : 8'($urandom);
         end
         tick();
      end
      i_start = 1'b0;
      i_wr_en = 1'b0;
      check("busy_in_wait", o_busy, 1);
      for (int w = 0; w < wait_cycles; w++) begin
         i_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         check("no_early_done", o_done, 0);
      end
      i_start = 1'b0;
      i_array_finish = 1'b1;
      tick();
      i_array_finish = 1'b0;
      check("done_pulse", o_done, 1);
      tick();
      check("done_one_cycle", o_done, 0);
      check("idle_after_done", o_busy, 0);
   endtask

   always @(negedge i_clock) begin
      if (i_reset) begin
         feed_left = 0;
         exp_feed.delete();
         exp_done_q.delete();
      end else begin
         if (feed_left > 0) begin
            if (exp_feed.size() == 0) begin
               check("feed_underflow", 1, 0);
            end else begin
               mon_e = exp_feed.pop_front();
               check("o_a", o_a, mon_e.a);
               check("o_b", o_b, mon_e.b);
            end
            check("array_reset_in_feed", o_array_reset, 0);
            feed_left--;
         end else if (o_array_reset) begin
            clears++;
            feed_left = 2*D - 1;
         end else begin
            check("lanes_idle", {o_a, o_b}, 0);
         end
         if (o_done) begin
            if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
            else void'(exp_done_q.pop_front());
         end
      end
   end

   initial begin
      clear_model();
      tick();
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_array_reset", o_array_reset, 0);
      check("rst_lanes", {o_a, o_b}, 0);
      tick();
      i_reset = 1'b0;
      tick();
      check("idle_busy", o_busy, 0);

      // Identity A against a ramp B.
      for (int r = 0; r < D; r++)
         for (int c = 0; c < D; c++) begin
            write_el(1'b0, r, c, (r == c) ? 8'd1 : 8'd0);
            write_el(1'b1, r, c, 8'(r*D + c + 1));
         end
      run_mult(2, 1'b0, 1'b0, 1'b0);

      // Uniform operands with i_start spam during FEED/WAIT.
      for (int r = 0; r < D; r++)
         for (int c = 0; c < D; c++) begin
            write_el(1'b0, r, c, 8'd2);
            write_el(1'b1, r, c, 8'd3);
         end
      run_mult(3, 1'b1, 1'b0, 1'b0);

      // Writes during a run are dropped; the next run feeds the old values.
      write_el(1'b0, 1, 2, 8'h11);
      run_mult(1, 1'b0, 1'b1, 1'b0);
      run_mult(0, 1'b0, 1'b0, 1'b0);

      // Out-of-range indices are dropped.
      write_el(1'b0, 4, 0, 8'hAA);
      write_el(1'b1, 0, 4, 8'hBB);
      write_el(1'b0, 7, 7, 8'hCC);
      run_mult(0, 1'b0, 1'b0, 1'b0);

      // Write committed together with i_start.
      run_mult(1, 1'b0, 1'b0, 1'b1);

      // Reset at FEED t=3 aborts the run and clears both stores.
      push_expected();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      i_reset = 1'b1;
      tick();
      check("abort_busy", o_busy, 0);
      check("abort_lanes", {o_a, o_b}, 0);
      check("abort_done", o_done, 0);
      clear_model();
      i_reset = 1'b0;
      tick();
      check("post_abort_busy", o_busy, 0);
      check("post_abort_done", o_done, 0);
      run_mult(0, 1'b0, 1'b0, 1'b0);

      for (int it = 0; it < 8; it++) begin
         for (int w = 0; w < 10; w++)
            write_el(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5), 8'($urandom));
         run_mult($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      tick();
      tick();
      check("feed_queue_empty", exp_feed.size(), 0);
      check("done_queue_empty", exp_done_q.size(), 0);
      check("clear_pulses", clears, runs);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
